op_scheduler: RTL and testbench
===============================

OP_SCHEDULER -- requirements
Module: op_scheduler

Interface
REQ-001 SHALL have parameter BW, default 16, operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TMO, default 64, watchdog limit in cycles for one operation.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port REQ  input  NREQ  per-requester request level; held until matching ACK.
REQ-007 SHALL have port IN0  input  NREQ*BW  flattened first operands, slice i = requester i.
REQ-008 SHALL have port IN1  input  NREQ*BW  flattened second operands, slice i = requester i.
REQ-009 SHALL have port ACK  output  NREQ  one-cycle completion pulse, one-hot.
REQ-010 SHALL have port RES  output  BW  result, valid in the ACK cycle.
REQ-011 SHALL have port ERR  output  1  asserted with ACK when the operation timed out.
REQ-012 SHALL have port OP_ST  output  1  start level to the shared operation unit.
REQ-013 SHALL have port OP_IN0  output  BW  operand 0 to the unit.
REQ-014 SHALL have port OP_IN1  output  BW  operand 1 to the unit.
REQ-015 SHALL have port OP_RD  input  1  ready from the unit.
REQ-016 SHALL have port OP_RES  input  BW  result from the unit, valid while OP_RD=1.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DONE, GAP.
REQ-018 IDLE: if any REQ=1, SHALL grant by round-robin starting at the index after the last-served one, latch the grant index and both operand slices, and enter ISSUE next cycle.
REQ-019 ISSUE: SHALL hold OP_ST=1 and drive OP_IN0/OP_IN1 from the latched operands; operands SHALL NOT change while ISSUE is active, even if the requester's inputs change.
REQ-020 ISSUE: OP_RD=1 sampled SHALL capture OP_RES into RES, clear ERR and go to DONE.
REQ-021 ISSUE: a watchdog counter SHALL count from 0; reaching TMO-1 without OP_RD SHALL set RES=0, ERR=1 and go to DONE.
REQ-022 If OP_RD and the timeout coincide in the same cycle, OP_RD SHALL win (ERR=0).
REQ-023 DONE: SHALL pulse ACK[grant]=1 for exactly one cycle, drive OP_ST=0, and go to GAP.
REQ-024 GAP: OP_ST SHALL stay 0 for one cycle so the unit returns to idle; then SHALL return to IDLE.
REQ-025 Issue-to-issue minimum spacing SHALL be 4 cycles; with OP_RD returning k cycles after OP_ST rises, ACK SHALL occur k+1 cycles after OP_ST rises.
REQ-026 A requester that drops REQ before ACK SHALL still receive its ACK; its result SHALL NOT be discarded.
REQ-027 The round-robin pointer SHALL update only on DONE; with one active requester, it SHALL be re-served back-to-back at the 4-cycle spacing.
REQ-028 The pointer SHALL wrap from NREQ-1 to 0.
REQ-029 RES and ERR SHALL hold their last value outside ACK cycles.

Reset
REQ-030 On RST=0, the block SHALL asynchronously enter IDLE with OP_ST=0, ACK=0, ERR=0, RES=0, OP_IN0=OP_IN1=0, watchdog=0, and pointer such that requester 0 has highest priority.
REQ-031 Reset mid-ISSUE SHALL abort the operation with no ACK; the deasserted OP_ST SHALL return the unit to idle.
REQ-032 Reset release SHALL be synchronised by the integrator; the block SHALL sample no REQ in the first post-release edge.

Structure
REQ-033 Package op_sched_pkg SHALL hold the FSM state encodings and the default BW, NREQ and TMO constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-035 Single request: REQ=0001, IN0[0]=0, IN1[0]=1, unit answers OP_RD after 3 cycles with OP_RES=16'h0003 -> ACK=0001, RES=0003, ERR=0.
REQ-036 All four requesting continuously -> ACK order 0001, 0010, 0100, 1000, 0001, each OP_IN0 equal to its own slice.
REQ-037 OP_RD never asserted, TMO=8 -> ACK after 8 ISSUE cycles with ERR=1, RES=0, next grant proceeds normally.
REQ-038 RST=0 pulse 2 cycles into ISSUE -> OP_ST=0 immediately, no ACK, next grant goes to requester 0.
REQ-039 Requester 2 changes IN0 during ISSUE -> OP_IN0 unchanged; OP_RD coincident with timeout -> ERR=0.

Source files
------------

// File: rtl/op_sched_pkg.sv
// Shared definitions for the operation scheduler: FSM state encoding and
// the default sizing constants used by the top-level parameters.
package op_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int DEF_BW   = 16;
    localparam int DEF_NREQ = 4;
    localparam int DEF_TMO  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester at index ptr_i has highest priority,
// priority then decreases with increasing index and wraps to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] gnt_hi;
    logic [N-1:0] gnt_all;

    // Positions at or above the pointer form the first search window.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_mask[gi] = (PW'(gi) >= ptr_i);
    end

    assign req_hi  = req_i & hi_mask;
    // Lowest set bit isolation; the wrapped search falls back to all requests.
    assign gnt_hi  = req_hi & (~req_hi + N'(1));
    assign gnt_all = req_i & (~req_i + N'(1));
    assign gnt_o   = (|req_hi) ? gnt_hi : gnt_all;

endmodule

// File: rtl/op_scheduler.sv
// Shares one multi-cycle operation unit among NREQ requesters. Each grant
// latches the requester's operands, holds start to the unit until it answers
// ready or a watchdog expires, then acknowledges with a one-cycle pulse.
module op_scheduler
    import op_sched_pkg::*;
#(
    parameter int BW   = DEF_BW,
    parameter int NREQ = DEF_NREQ,
    parameter int TMO  = DEF_TMO
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*BW-1:0] IN0,
    input  logic [NREQ*BW-1:0] IN1,
    output logic [NREQ-1:0]    ACK,
    output logic [BW-1:0]      RES,
    output logic               ERR,
    output logic               OP_ST,
    output logic [BW-1:0]      OP_IN0,
    output logic [BW-1:0]      OP_IN1,
    input  logic               OP_RD,
    input  logic [BW-1:0]      OP_RES
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [BW-1:0]   opa_q, opa_d;
    logic [BW-1:0]   opb_q, opb_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [BW-1:0]   res_q, res_d;
    logic            err_q, err_d;
    logic            arm_q;

    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] gnt_oh;
    logic [PW-1:0]   gnt_idx;
    logic [BW-1:0]   in0_arr [NREQ];
    logic [BW-1:0]   in1_arr [NREQ];

    // Unflatten the operand buses into per-requester slices.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign in0_arr[gi] = IN0[gi*BW +: BW];
        assign in1_arr[gi] = IN1[gi*BW +: BW];
    end

    // Requests are ignored on the first edge after reset release.
    assign req_eff = REQ & {NREQ{arm_q}};

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh)
    );

    // One-hot grant to binary index: bit gj of the index is the OR of the
    // grant lines whose position has bit gj set.
    for (genvar gj = 0; gj < PW; gj++) begin : g_enc
        logic [NREQ-1:0] sel;
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_bit
            assign sel[gi] = (((gi >> gj) % 2) == 1) ? gnt_oh[gi] : 1'b0;
        end
        assign gnt_idx[gj] = |sel;
    end

    // Next-state logic: grant, issue with watchdog, acknowledge, idle gap.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        wdog_d  = wdog_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|req_eff) begin
                    gidx_d  = gnt_idx;
                    opa_d   = in0_arr[gnt_idx];
                    opb_d   = in1_arr[gnt_idx];
                    wdog_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Ready wins over a coincident watchdog expiry.
                if (OP_RD) begin
                    res_d   = OP_RES;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wdog_q == WW'(TMO - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            DONE: begin
                ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
                wdog_d  = '0;
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            wdog_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wdog_q  <= wdog_d;
            res_q   <= res_d;
            err_q   <= err_d;
            arm_q   <= 1'b1;
        end
    end

    // Completion pulse for the latched grant, only in the DONE cycle.
    always_comb begin
        ACK = '0;
        if (state_q == DONE) begin
            ACK[gidx_q] = 1'b1;
        end
    end

    assign OP_ST  = (state_q == ISSUE);
    assign OP_IN0 = opa_q;
    assign OP_IN1 = opb_q;
    assign RES    = res_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Self-checking bench for op_scheduler: a transaction-level model predicts
// grant order, completion timing and results; a responder models the unit.
module tb_op_scheduler;

    localparam int BW   = 16;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    REQ;
    logic [NREQ*BW-1:0] IN0;
    logic [NREQ*BW-1:0] IN1;
    logic [NREQ-1:0]    ACK;
    logic [BW-1:0]      RES;
    logic               ERR;
    logic               OP_ST;
    logic [BW-1:0]      OP_IN0;
    logic [BW-1:0]      OP_IN1;
    logic               OP_RD;
    logic [BW-1:0]      OP_RES;

    int n_checks = 0;
    int n_pass   = 0;

    op_scheduler #(
        .BW   (BW),
        .NREQ (NREQ),
        .TMO  (TMO)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .IN0    (IN0),
        .IN1    (IN1),
        .ACK    (ACK),
        .RES    (RES),
        .ERR    (ERR),
        .OP_ST  (OP_ST),
        .OP_IN0 (OP_IN0),
        .OP_IN1 (OP_IN1),
        .OP_RD  (OP_RD),
        .OP_RES (OP_RES)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- unit responder ----------------
    int cur_k   = 0;     // latency chosen for the current operation
    int force_k = -1;    // directed override of the latency (-1 = random)
    int u_cnt   = 0;
    bit u_prev  = 1'b0;

    always @(negedge CLK) begin
        if (OP_ST && !u_prev) u_cnt = 0;
        else if (OP_ST) u_cnt++;
        u_prev = OP_ST;
        if (OP_ST && u_cnt == cur_k) begin
            OP_RD  = 1'b1;
            OP_RES = OP_IN0 + OP_IN1 + OP_IN1 + OP_IN1;
        end else begin
            OP_RD  = 1'b0;
            OP_RES = BW'($urandom);
        end
    end

    // ---------------- transaction model + compare ----------------
    int            ecnt = 0;
    bit            armed = 1'b0, busy = 1'b0, found;
    logic [1:0]    mptr = 2'd0, m_idx = 2'd0, cand;
    int            m_g = 0, m_d = 0, m_ack_edge = 0, k, r;
    logic [BW-1:0] m_a = '0, m_b = '0, m_exp_res = '0, m_res = '0;
    bit            m_exp_err = 1'b0, m_err = 1'b0, exp_st;
    logic [NREQ-1:0] exp_ack;

    always @(posedge CLK) begin
        ecnt++;
        if (!RST) begin
            armed = 1'b0; busy = 1'b0; mptr = 2'd0; m_res = '0; m_err = 1'b0;
        end else if (!armed) begin
            armed = 1'b1;
        end else begin
            if (busy && ecnt == m_ack_edge) begin
                m_res = m_exp_res;
                m_err = m_exp_err;
            end
            if (busy && ecnt >= m_ack_edge + 3) busy = 1'b0;
            if (!busy && REQ != '0) begin
                found = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    cand = mptr + 2'(j);
                    if (!found && REQ[cand]) begin
                        found = 1'b1;
                        m_idx = cand;
                    end
                end
                m_a = BW'(IN0 >> (32'(m_idx) * BW));
                m_b = BW'(IN1 >> (32'(m_idx) * BW));
                if (force_k >= 0) k = force_k;
                else begin
                    r = int'($urandom_range(0, 9));
                    if (r <= 5) k = r;
                    else if (r == 6) k = TMO - 1;
                    else if (r == 7) k = TMO + 3;
                    else k = int'($urandom_range(0, 3));
                end
                cur_k      = k;
                m_d        = (k < TMO) ? k : TMO - 1;
                m_g        = ecnt;
                m_ack_edge = ecnt + m_d + 1;
                m_exp_err  = (k >= TMO);
                m_exp_res  = (k < TMO) ? (m_a + m_b + m_b + m_b) : '0;
                mptr       = m_idx + 2'd1;
                busy       = 1'b1;
            end
        end
        #3;
        exp_st  = busy && ecnt >= m_g && ecnt <= m_g + m_d;
        exp_ack = '0;
        if (busy && ecnt == m_ack_edge) exp_ack = NREQ'(1) << m_idx;
        chk("op_st", 32'(OP_ST), 32'(exp_st));
        chk("ack", 32'(ACK), 32'(exp_ack));
        chk("res", 32'(RES), 32'(m_res));
        chk("err", 32'(ERR), 32'(m_err));
        if (!RST) begin
            chk("rst_op_in0", 32'(OP_IN0), 32'd0);
            chk("rst_op_in1", 32'(OP_IN1), 32'd0);
        end else if (exp_st) begin
            chk("op_in0", 32'(OP_IN0), 32'(m_a));
            chk("op_in1", 32'(OP_IN1), 32'(m_b));
        end
        if (exp_ack != '0)
            $display("txn ack=%b res=%h err=%0d model_res=%h model_err=%0d t=%0t",
                     ACK, RES, ERR, m_res, m_err, $time);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(output logic [NREQ-1:0] a, output int lat, output int cyc);
        int rise = -1;
        bit got  = 1'b0;
        a = '0; lat = -1; cyc = -1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge CLK); #4;
            if (OP_ST && rise < 0) rise = c;
            if (ACK != '0) begin
                a = ACK; lat = c - rise; cyc = c + 1; got = 1'b1;
            end
        end
    endtask

    task automatic wait_st(input string name);
        bit got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge CLK); #4;
            if (OP_ST) got = 1'b1;
        end
        chk(name, 32'(OP_ST), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        REQ = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    logic [NREQ-1:0] a_got, drop;
    int lat, cyc;

    initial begin
        RST = 1'b1; REQ = '0; IN0 = '0; IN1 = '0;
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ack", 32'(ACK), 32'd0);
        chk("reset_res", 32'(RES), 32'd0);
        chk("reset_err", 32'(ERR), 32'd0);
        chk("reset_op_st", 32'(OP_ST), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single request, unit answers after 3 cycles.
        IN0 = '0; IN1 = 64'h0000_0000_0000_0001;
        force_k = 3; REQ = 4'b0001;
        wait_ack(a_got, lat, cyc);
        chk("t1_ack", 32'(a_got), 32'h1);
        chk("t1_res", 32'(RES), 32'h3);
        chk("t1_err", 32'(ERR), 32'd0);
        chk("t1_latency", 32'(lat), 32'd4);
        @(negedge CLK); REQ = '0;

        // All requesting continuously after reset: strict rotation from 0.
        do_reset();
        IN0 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        IN1 = {16'd3, 16'd2, 16'd1, 16'd0};
        force_k = 0; REQ = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(a_got, lat, cyc);
            chk("t2_ack_order", 32'(a_got), 32'(1 << (j % 4)));
            chk("t2_res", 32'(RES), 32'h1000 + 32'(4 * (j % 4)));
            if (j > 0) chk("t2_spacing", 32'(cyc), 32'd4);
        end
        @(negedge CLK); REQ = '0;

        // Unit never answers: watchdog completion, then a normal operation.
        @(negedge CLK);
        force_k = 99; REQ = 4'b0010;
        wait_ack(a_got, lat, cyc);
        chk("t3_ack", 32'(a_got), 32'h2);
        chk("t3_err", 32'(ERR), 32'd1);
        chk("t3_res", 32'(RES), 32'd0);
        chk("t3_latency", 32'(lat), 32'd8);
        @(negedge CLK);
        REQ = 4'b0001; force_k = 2;
        IN0 = 64'h0000_0000_0000_0005; IN1 = 64'h0000_0000_0000_0001;
        wait_ack(a_got, lat, cyc);
        chk("t3b_ack", 32'(a_got), 32'h1);
        chk("t3b_err", 32'(ERR), 32'd0);
        chk("t3b_res", 32'(RES), 32'h8);
        chk("t3b_latency", 32'(lat), 32'd3);
        @(negedge CLK); REQ = '0;

        // Reset two cycles into an operation: abort, priority back to 0.
        @(negedge CLK);
        force_k = 99; REQ = 4'b0100;
        wait_st("t4_issue_seen");
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t4_rst_op_st", 32'(OP_ST), 32'd0);
        chk("t4_rst_ack", 32'(ACK), 32'd0);
        REQ = 4'b1111; force_k = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        wait_ack(a_got, lat, cyc);
        chk("t4_next_grant", 32'(a_got), 32'h1);
        chk("t4_latency", 32'(lat), 32'd1);
        @(negedge CLK); REQ = '0;

        // Operands change during the operation; ready coincides with timeout.
        @(negedge CLK);
        IN0 = {16'h0, 16'h0011, 16'h0, 16'h0};
        IN1 = {16'h0, 16'h0002, 16'h0, 16'h0};
        force_k = TMO - 1; REQ = 4'b0100;
        wait_st("t5_issue_seen");
        @(negedge CLK);
        IN0 = {16'h0, 16'hBEEF, 16'h0, 16'h0};
        IN1 = {16'h0, 16'h7777, 16'h0, 16'h0};
        @(posedge CLK); #4;
        chk("t5_op_in0_hold", 32'(OP_IN0), 32'h0011);
        chk("t5_op_in1_hold", 32'(OP_IN1), 32'h0002);
        wait_ack(a_got, lat, cyc);
        chk("t5_ack", 32'(a_got), 32'h4);
        chk("t5_err", 32'(ERR), 32'd0);
        chk("t5_res", 32'(RES), 32'h0017);
        @(negedge CLK); REQ = '0;

        // Randomized traffic: requests held until ACK, occasional early drops.
        force_k = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            REQ  = REQ & ~ACK;
            drop = ($urandom_range(0, 19) == 0) ? NREQ'($urandom) : '0;
            REQ  = (REQ | (NREQ'($urandom) & NREQ'($urandom))) & ~drop;
            if ($urandom_range(0, 1) == 1) IN0 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) IN1 = {$urandom, $urandom};
        end
        @(negedge CLK); REQ = '0;
        repeat (40) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
